// File: rtl/io_out_serializer.sv
// io_out_serializer
//   Parallel-to-serial driver for one IO buffer (PADDO + active-high tristate T).
//   Words arrive over valid/ready and leave LSB first, one bit per clk. Each burst
//   is framed by one lead and one trail cycle of driven IDLE_LEVEL. A word offered
//   while the last bit of the current word is on the pad is chained without a gap.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous reset, active high
//   s_valid  in   1      upstream word valid
//   s_ready  out  1      word accepted on this edge if s_valid is high
//   s_data   in   WIDTH  word to serialize, bit 0 first
//   paddo    out  1      to IO buffer PADDO
//   padt     out  1      to IO buffer T (1 = pad released)
//   busy     out  1      high whenever the FSM is not in IDLE
//
// State  | meaning
// IDLE   | pad parked at IDLE_LEVEL / TRISTATE_WHEN_IDLE, ready for a word
// LEAD   | one driven IDLE_LEVEL cycle before the first data bit
// SHIFT  | data bit sr[0] on the pad, cnt = index of that bit
// TRAIL  | one driven IDLE_LEVEL cycle after the last data bit

module io_out_serializer #(
  parameter int   WIDTH              = 8,
  parameter logic IDLE_LEVEL         = 1'b1,
  parameter logic TRISTATE_WHEN_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             paddo,
  output logic             padt,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] TRAIL = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  // Ready depends on flops only, so there is no s_valid -> s_ready path.
  always_comb begin
    s_ready = 1'b0;
    if (state == IDLE)
      s_ready = 1'b1;
    else if (state == SHIFT && cnt_last)
      s_ready = 1'b1;
  end

  // Pad outputs decoded purely from flops: no input-to-pad combinational path.
  always_comb begin
    paddo = IDLE_LEVEL;
    padt  = 1'b0;
    busy  = 1'b1;
    case (state)
      IDLE: begin
        padt = TRISTATE_WHEN_IDLE;
        busy = 1'b0;
      end
      SHIFT:   paddo = sr[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            sr    <= s_data;
            state <= LEAD;
          end
        end
        LEAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (cnt_last) begin
            // Last bit on the pad: chain the next word or close the burst.
            // cnt is reset either way so it never steps past WIDTH-1.
            cnt <= '0;
            if (s_valid) begin
              sr <= s_data;
            end else begin
              sr    <= sr >> 1;
              state <= TRAIL;
            end
          end else begin
            sr  <= sr >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_out_serializer.sv
module tb_io_out_serializer;

  typedef logic [3:0] exp_t;  // {paddo, padt, s_ready, busy}

  logic       clk;
  logic       rst;
  logic       s_valid, s_ready, paddo, padt, busy;
  logic [7:0] s_data;
  logic       s_valid_z, s_ready_z, paddo_z, padt_z, busy_z;
  logic [7:0] s_data_z;

  int tests;
  int fails;
  exp_t sb_q[$];

  io_out_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1), .TRISTATE_WHEN_IDLE(1'b1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .paddo(paddo), .padt(padt), .busy(busy)
  );

  io_out_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0), .TRISTATE_WHEN_IDLE(1'b0)) dut_z (
    .clk(clk), .rst(rst), .s_valid(s_valid_z), .s_ready(s_ready_z), .s_data(s_data_z),
    .paddo(paddo_z), .padt(padt_z), .busy(busy_z)
  );

  always #5 clk = ~clk;

  // Expected pad stream for one word: optional lead, 8 data bits LSB first, optional trail.
  task automatic push_word(input logic [7:0] d, input logic lvl, input bit lead, input bit trail);
    if (lead) sb_q.push_back({lvl, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 8; k++) sb_q.push_back({d[k], 1'b0, (k == 7), 1'b1});
    if (trail) sb_q.push_back({lvl, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_reset();
    exp_t got;
    #2 rst = 1'b1;
    #1;
    got = {paddo, padt, s_ready, busy};
    tests++;
    if (got !== 4'b1110) begin
      fails++;
      $display("FAIL reset_async: got %b required %b", got, 4'b1110);
    end
    got = {paddo_z, padt_z, s_ready_z, busy_z};
    tests++;
    if (got !== 4'b0010) begin
      fails++;
      $display("FAIL reset_async_z: got %b required %b", got, 4'b0010);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== 4'b1110) begin
        fails++;
        $display("FAIL idle_hold cycle %0d: got %b required %b", i, got, 4'b1110);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    exp_t e, got;
    int n;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    push_word(8'hA5, 1'b1, 1'b1, 1'b1);
    sb_q.push_back(4'b1110);
    @(posedge clk);
    #1 s_valid = 1'b0;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL single_a5 item %0d: got %b required %b", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int n;
    s_valid = 1'b1;
    s_data  = 8'h01;
    push_word(8'h01, 1'b1, 1'b1, 1'b0);
    push_word(8'hFF, 1'b1, 1'b0, 1'b1);
    sb_q.push_back(4'b1110);
    @(posedge clk);
    #1 s_data = 8'hFF;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL back_to_back item %0d: got %b required %b", i, got, e);
      end
      @(posedge clk);
      #1;
      if (i == 8) s_valid = 1'b0;
    end
  endtask

  task automatic test_valid_in_trail();
    exp_t e, got;
    int n;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    push_word(8'h5A, 1'b1, 1'b1, 1'b1);
    sb_q.push_back(4'b1110);
    push_word(8'h3C, 1'b1, 1'b1, 1'b1);
    sb_q.push_back(4'b1110);
    @(posedge clk);
    #1 s_valid = 1'b0;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL valid_in_trail item %0d: got %b required %b", i, got, e);
      end
      @(posedge clk);
      #1;
      if (i == 8) begin
        s_valid = 1'b1;
        s_data  = 8'h3C;
      end
      if (i == 10) s_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_t e, got;
    s_valid = 1'b1;
    s_data  = 8'hF0;
    sb_q.push_back(4'b1001);
    for (int k = 0; k < 4; k++) sb_q.push_back(4'b0001);
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL pre_abort item %0d: got %b required %b", i, got, e);
      end
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    got = {paddo, padt, s_ready, busy};
    tests++;
    if (got !== 4'b1110) begin
      fails++;
      $display("FAIL abort_immediate: got %b required %b", got, 4'b1110);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      got = {paddo, padt, s_ready, busy};
      tests++;
      if (got !== 4'b1110) begin
        fails++;
        $display("FAIL post_abort cycle %0d: got %b required %b", i, got, 4'b1110);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_driven_idle_low();
    exp_t e, got;
    int n;
    s_valid_z = 1'b1;
    s_data_z  = 8'h81;
    push_word(8'h81, 1'b0, 1'b1, 1'b1);
    sb_q.push_back(4'b0010);
    sb_q.push_back(4'b0010);
    @(posedge clk);
    #1 s_valid_z = 1'b0;
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {paddo_z, padt_z, s_ready_z, busy_z};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL driven_idle_81 item %0d: got %b required %b", i, got, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clk       = 1'b0;
    rst       = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    s_valid_z = 1'b0;
    s_data_z  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_in_trail();
    test_reset_mid_burst();
    test_driven_idle_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
